keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad, debounces presses and decodes each accepted key into one-cycle event pulses for the calculator control FSM. It is the stage directly upstream of the control FSM: op_recived and eq_recived feed that FSM's operator/equals inputs. digit_valid/digit feed the operand registers. clr_recived feeds the clear logic.

Parameters:
SCAN_DIV, 1000, clk cycles per column period; must be >= 2.
DEBOUNCE_SCANS, 4, consecutive matching column-period samples needed to accept a press or a release; must be >= 1.

Ports:
clk  input  1  system clock; single clock domain.
rst  input  1  asynchronous, active-high reset.
row_in  input  4  keypad rows; pulled up, active-low; asynchronous to clk.
col_out  output  4  column drive; active-low, exactly one bit low.
key_valid  output  1  one-cycle pulse per accepted key.
key_code  output  4  code of the last accepted key; held until the next accept.
digit_valid  output  1  one-cycle pulse when the accepted key is 0-9.
digit  output  4  value 0-9 of the last accepted digit.
op_recived  output  1  one-cycle pulse for + - * /.
op_code  output  2  00 +, 01 -, 10 *, 11 /; held until the next operator.
eq_recived  output  1  one-cycle pulse for =.
clr_recived  output  1  one-cycle pulse for C.

Behaviour:
- Reset (async, effective immediately, also mid-operation):
  - col_out=4'b1110; all pulses 0; key_code=0, digit=0, op_code=0.
  - State SCAN; all counters 0; synchronizer flops set to 4'b1111.
- row_in passes through a 2-flop synchronizer before any use.
- Divider div_cnt counts 0..SCAN_DIV-1 and wraps. A sample event occurs when div_cnt==SCAN_DIV-1, using the synchronized rows.
- Keypad layout, key_code in brackets:
  - row0: 1[1] 2[2] 3[3] +[10]
  - row1: 4[4] 5[5] 6[6] -[11]
  - row2: 7[7] 8[8] 9[9] *[12]
  - row3: C[14] 0[0] =[15] /[13]
  - The column index is the position of the low bit in col_out; col0 = bit0.
- State SCAN:
  - At a sample event with all rows high: rotate col_out left (1110->1101->1011->0111->1110).
  - At a sample event with exactly one row low: latch row/col, clear deb_cnt to 1, go to DEBOUNCE, and hold col_out.
  - At a sample event with two or more rows low: treat as ghosting, ignore it, and rotate as normal.
- State DEBOUNCE:
  - Each sample event with the same single row low increments deb_cnt.
  - When deb_cnt reaches DEBOUNCE_SCANS: the next cycle drives key_valid and the one class pulse high for exactly 1 cycle, and updates key_code/digit/op_code. Then go to HELD.
  - Any other row pattern at a sample event: return to SCAN, rotate col_out, no pulse.
  - When DEBOUNCE_SCANS=1, acceptance happens on the first sample (the detecting sample counts).
- State HELD:
  - col_out is held and no further pulses are produced (no auto-repeat).
  - Each sample event with all rows high increments rel_cnt; any low row clears rel_cnt.
  - When rel_cnt reaches DEBOUNCE_SCANS: go to SCAN, rotate col_out, clear rel_cnt.
- Latency: pulse asserted 1 clk after the accepting sample event.
- At most one pulse output is high in any cycle, and pulses never occur on consecutive cycles.
- A second key pressed while in HELD is ignored. The first key must be fully released before a new accept.
- Counter widths: $clog2(SCAN_DIV) for div_cnt and $clog2(DEBOUNCE_SCANS+1) for deb_cnt/rel_cnt. Counters must not overflow: they saturate or leave their state first.

Decomposition:
- Package calc_pkg holds:
  - key_code localparams (KEY_PLUS=10 .. KEY_EQ=15);
  - op_code localparams (OP_ADD..OP_DIV);
  - scanner state encoding (SCAN, DEBOUNCE, HELD);
  - the row/col-to-key_code lookup function.
- One sub-module: row_sync, a 4-bit 2-flop synchronizer with async reset to 1s.

Test Plan:
- Bench parameters for all cases: SCAN_DIV=4, DEBOUNCE_SCANS=3.
- Assert rst mid-cycle -> col_out=1110 and all pulses 0 immediately. Release -> col_out rotates every 4 clks.
- Hold key 5 (row1 low while col1 driven) for 20 periods -> exactly one digit_valid+key_valid pulse, digit=5, key_code=5, no repeat. Release for 3 periods -> scanning resumes.
- Press + then =, each with a clean release -> one op_recived with op_code=00, then one eq_recived. key_code goes 10 then 15.
- Press C -> one clr_recived pulse, key_code=14.
- Bounce: row low for 1 period then high -> no pulses, state returns to SCAN.
- Ghost: rows 0 and 2 both low on col0 -> no pulse. Scan continues to col1.
- Press 7, then press 9 while 7 is still held, then release both -> only the 7 pulse (digit=7). A fresh 9 press afterwards -> digit=9.
- Assert rst while in HELD -> outputs return to reset values and col_out=1110. No pulse after release.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared key codes, operator codes, scanner state encoding and keypad lookup
// helpers for the calculator front end.
package calc_pkg;

    localparam logic [3:0] KEY_PLUS  = 4'd10;
    localparam logic [3:0] KEY_MINUS = 4'd11;
    localparam logic [3:0] KEY_MUL   = 4'd12;
    localparam logic [3:0] KEY_DIV   = 4'd13;
    localparam logic [3:0] KEY_CLR   = 4'd14;
    localparam logic [3:0] KEY_EQ    = 4'd15;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scan_state_e;

    // Physical keypad layout: row index 0..3 top to bottom, col index = low bit of col_out.
    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = 4'd0;
        case ({row, col})
            4'b00_00: code = 4'd1;
            4'b00_01: code = 4'd2;
            4'b00_10: code = 4'd3;
            4'b00_11: code = KEY_PLUS;
            4'b01_00: code = 4'd4;
            4'b01_01: code = 4'd5;
            4'b01_10: code = 4'd6;
            4'b01_11: code = KEY_MINUS;
            4'b10_00: code = 4'd7;
            4'b10_01: code = 4'd8;
            4'b10_10: code = 4'd9;
            4'b10_11: code = KEY_MUL;
            4'b11_00: code = KEY_CLR;
            4'b11_01: code = 4'd0;
            4'b11_10: code = KEY_EQ;
            default:  code = KEY_DIV;
        endcase
        return code;
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus decoded key-event outputs toward the control FSM.
interface keypad_scanner_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       key_valid;
    logic [3:0] key_code;
    logic       digit_valid;
    logic [3:0] digit;
    logic       op_recived;
    logic [1:0] op_code;
    logic       eq_recived;
    logic       clr_recived;

    modport master (
        input  row_in,
        output col_out, key_valid, key_code, digit_valid, digit,
               op_recived, op_code, eq_recived, clr_recived
    );

    modport slave (
        output row_in,
        input  col_out, key_valid, key_code, digit_valid, digit,
               op_recived, op_code, eq_recived, clr_recived
    );
endinterface

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up keypad rows.
module row_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);
    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column rotation, press/release debounce and decode of
// each accepted key into one-cycle class pulses.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input logic               clk,
    input logic               rst,
    keypad_scanner_if.master  kp
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W:0]   CNT_MAX  = (CNT_W+1)'(DEBOUNCE_SCANS);
    localparam bit               DEB_ONE  = (DEBOUNCE_SCANS == 1);

    scan_state_e      state_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] deb_cnt_q, rel_cnt_q;
    logic [3:0]       col_out_q;
    logic [1:0]       row_q;
    logic             key_valid_q, digit_valid_q, op_q, eq_q, clr_q;
    logic [3:0]       key_code_q, digit_q;
    logic [1:0]       op_code_q;

    logic [3:0] rows_s;
    logic       sample, single_low, same_row, accept;
    logic [1:0] row_idx, col_idx;
    logic [3:0] hit_code;
    logic [CNT_W:0] deb_next, rel_next;

    row_sync u_row_sync (
        .clk (clk),
        .rst (rst),
        .d_i (kp.row_in),
        .q_o (rows_s)
    );

    assign sample     = (div_cnt_q == DIV_LAST);
    assign single_low = $onehot(~rows_s);
    assign row_idx    = low_index(rows_s);
    assign col_idx    = low_index(col_out_q);
    assign hit_code   = key_lookup(row_idx, col_idx);
    assign same_row   = single_low && (row_idx == row_q);
    assign deb_next   = {1'b0, deb_cnt_q} + (CNT_W+1)'(1);
    assign rel_next   = {1'b0, rel_cnt_q} + (CNT_W+1)'(1);
    // The column is frozen outside SCAN, so the current col_idx is the latched column.
    assign accept = sample && single_low &&
                    ((state_q == SCAN && DEB_ONE) ||
                     (state_q == DEBOUNCE && same_row && deb_next == CNT_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= SCAN;
            div_cnt_q     <= '0;
            deb_cnt_q     <= '0;
            rel_cnt_q     <= '0;
            col_out_q     <= 4'b1110;
            row_q         <= 2'd0;
            key_valid_q   <= 1'b0;
            digit_valid_q <= 1'b0;
            op_q          <= 1'b0;
            eq_q          <= 1'b0;
            clr_q         <= 1'b0;
            key_code_q    <= 4'd0;
            digit_q       <= 4'd0;
            op_code_q     <= OP_ADD;
        end else begin
            key_valid_q   <= 1'b0;
            digit_valid_q <= 1'b0;
            op_q          <= 1'b0;
            eq_q          <= 1'b0;
            clr_q         <= 1'b0;
            div_cnt_q     <= sample ? '0 : div_cnt_q + DIV_W'(1);

            if (accept) begin
                key_valid_q <= 1'b1;
                key_code_q  <= hit_code;
                if (hit_code <= 4'd9) begin
                    digit_valid_q <= 1'b1;
                    digit_q       <= hit_code;
                end else if (hit_code == KEY_CLR) begin
                    clr_q <= 1'b1;
                end else if (hit_code == KEY_EQ) begin
                    eq_q <= 1'b1;
                end else begin
                    op_q      <= 1'b1;
                    op_code_q <= 2'(hit_code - KEY_PLUS);
                end
            end

            if (sample) begin
                case (state_q)
                    SCAN: begin
                        if (single_low) begin
                            row_q     <= row_idx;
                            deb_cnt_q <= accept ? '0 : CNT_W'(1);
                            state_q   <= accept ? HELD : DEBOUNCE;
                        end else begin
                            col_out_q <= {col_out_q[2:0], col_out_q[3]};
                        end
                    end
                    DEBOUNCE: begin
                        if (accept) begin
                            deb_cnt_q <= '0;
                            state_q   <= HELD;
                        end else if (same_row) begin
                            deb_cnt_q <= deb_next[CNT_W-1:0];
                        end else begin
                            deb_cnt_q <= '0;
                            col_out_q <= {col_out_q[2:0], col_out_q[3]};
                            state_q   <= SCAN;
                        end
                    end
                    HELD: begin
                        if (rows_s != 4'hF) begin
                            rel_cnt_q <= '0;
                        end else if (rel_next == CNT_MAX) begin
                            rel_cnt_q <= '0;
                            col_out_q <= {col_out_q[2:0], col_out_q[3]};
                            state_q   <= SCAN;
                        end else begin
                            rel_cnt_q <= rel_next[CNT_W-1:0];
                        end
                    end
                    default: state_q <= SCAN;
                endcase
            end
        end
    end

    assign kp.col_out     = col_out_q;
    assign kp.key_valid   = key_valid_q;
    assign kp.key_code    = key_code_q;
    assign kp.digit_valid = digit_valid_q;
    assign kp.digit       = digit_q;
    assign kp.op_recived  = op_q;
    assign kp.op_code     = op_code_q;
    assign kp.eq_recived  = eq_q;
    assign kp.clr_recived = clr_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives the rows from the
// pressed-key set; a monitor collects accepted-key events for the tests.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DS = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    keypad_scanner_if kp();

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    // Pressed keys, bit index = row*4 + col.
    logic [15:0] pressed = 16'd0;
    int layout [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    function automatic logic [3:0] row_model(input logic [15:0] p, input logic [3:0] col);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (p[i*4+j] && !col[j]) r[i] = 1'b0;
        return r;
    endfunction

    assign kp.row_in = row_model(pressed, kp.col_out);

    function automatic int pos_of(input int code);
        int p;
        p = 0;
        for (int i = 0; i < 16; i++) if (layout[i] == code) p = i;
        return p;
    endfunction

    // Class of a key: 0 digit, 1 operator, 2 equals, 3 clear.
    function automatic int cls_of(input int code);
        if (code <= 9) return 0;
        if (code <= 13) return 1;
        if (code == 15) return 2;
        return 3;
    endfunction

    function automatic logic [3:0] rotl(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    typedef struct {
        logic [3:0] code;
        int         cls;
        logic [3:0] dig;
        logic [1:0] op;
    } ev_t;

    ev_t evq[$];
    int  errors = 0;
    int  checks = 0;
    bit  prev_pulse = 0;

    always @(negedge clk) begin : monitor
        int   n;
        ev_t  e;
        if (rst) begin
            prev_pulse = 0;
        end else begin
            n = int'(kp.digit_valid) + int'(kp.op_recived) + int'(kp.eq_recived) + int'(kp.clr_recived);
            if (n != 0 || kp.key_valid) begin
                checks++;
                if (kp.key_valid !== 1'b1 || n != 1) begin
                    errors++;
                    $display("FAIL pulse_excl: key_valid=%b class pulses=%0d, required 1 and 1", kp.key_valid, n);
                end
                checks++;
                if (prev_pulse) begin
                    errors++;
                    $display("FAIL pulse_gap: pulse on consecutive cycles, required a gap");
                end
                if (kp.key_valid) begin
                    e.code = kp.key_code;
                    e.cls  = kp.digit_valid ? 0 : kp.op_recived ? 1 : kp.eq_recived ? 2 : kp.clr_recived ? 3 : -1;
                    e.dig  = kp.digit;
                    e.op   = kp.op_code;
                    evq.push_back(e);
                end
                prev_pulse = 1;
            end else begin
                prev_pulse = 0;
            end
        end
    end

    task automatic wait_per(input int n);
        repeat (n * SD) @(posedge clk);
    endtask

    task automatic press(input int code);
        pressed = pressed | (16'd1 << pos_of(code));
    endtask

    task automatic release_all();
        pressed = 16'd0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        wait_per(6);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (kp.col_out !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b required 1110", kp.col_out); end
        checks++;
        if ({kp.key_valid, kp.digit_valid, kp.op_recived, kp.eq_recived, kp.clr_recived} !== 5'b0) begin
            errors++; $display("FAIL reset_pulses: got %b required 00000",
                {kp.key_valid, kp.digit_valid, kp.op_recived, kp.eq_recived, kp.clr_recived});
        end
        checks++;
        if ({kp.key_code, kp.digit, kp.op_code} !== 10'd0) begin
            errors++; $display("FAIL reset_regs: key_code=%0d digit=%0d op_code=%0d required 0", kp.key_code, kp.digit, kp.op_code);
        end
        @(negedge clk) rst = 1'b0;
        exp_col = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            repeat (SD - 1) @(posedge clk);
            #1;
            checks++;
            if (kp.col_out !== exp_col) begin errors++; $display("FAIL rot_hold%0d: got %b required %b", k, kp.col_out, exp_col); end
            @(posedge clk);
            #1;
            exp_col = rotl(exp_col);
            checks++;
            if (kp.col_out !== exp_col) begin errors++; $display("FAIL rot_step%0d: got %b required %b", k, kp.col_out, exp_col); end
        end
    endtask

    task automatic test_digit5();
        logic [3:0] c0;
        bit moved;
        evq.delete();
        press(5);
        wait_per(20);
        checks++;
        if (evq.size() != 1) begin errors++; $display("FAIL d5_count: got %0d events required 1", evq.size()); end
        else if (evq[0].code !== 4'd5 || evq[0].cls != 0 || evq[0].dig !== 4'd5) begin
            errors++; $display("FAIL d5_event: code=%0d cls=%0d digit=%0d required 5/0/5", evq[0].code, evq[0].cls, evq[0].dig);
        end
        checks++;
        if (kp.col_out !== 4'b1101) begin errors++; $display("FAIL d5_colhold: got %b required 1101", kp.col_out); end
        release_all();
        c0 = kp.col_out;
        moved = 0;
        for (int i = 0; i < 8 * SD && !moved; i++) begin
            @(posedge clk);
            #1;
            if (kp.col_out !== c0) moved = 1;
        end
        checks++;
        if (!moved) begin errors++; $display("FAIL d5_resume: col_out stuck at %b, required rotation", c0); end
        wait_per(3);
        checks++;
        if (evq.size() != 1 || kp.key_code !== 4'd5) begin
            errors++; $display("FAIL d5_norepeat: events=%0d key_code=%0d required 1 and 5", evq.size(), kp.key_code);
        end
    endtask

    task automatic test_plus_eq();
        evq.delete();
        press(10); wait_per(12); release_all(); wait_per(6);
        press(15); wait_per(12); release_all(); wait_per(6);
        checks++;
        if (evq.size() != 2) begin errors++; $display("FAIL pe_count: got %0d events required 2", evq.size()); end
        else begin
            checks++;
            if (evq[0].code !== 4'd10 || evq[0].cls != 1 || evq[0].op !== 2'b00) begin
                errors++; $display("FAIL pe_plus: code=%0d cls=%0d op=%b required 10/1/00", evq[0].code, evq[0].cls, evq[0].op);
            end
            checks++;
            if (evq[1].code !== 4'd15 || evq[1].cls != 2) begin
                errors++; $display("FAIL pe_eq: code=%0d cls=%0d required 15/2", evq[1].code, evq[1].cls);
            end
        end
        checks++;
        if (kp.key_code !== 4'd15 || kp.op_code !== 2'b00) begin
            errors++; $display("FAIL pe_held: key_code=%0d op_code=%b required 15/00", kp.key_code, kp.op_code);
        end
    endtask

    task automatic test_clear();
        evq.delete();
        press(14); wait_per(12); release_all(); wait_per(6);
        checks++;
        if (evq.size() != 1) begin errors++; $display("FAIL clr_count: got %0d events required 1", evq.size()); end
        else if (evq[0].code !== 4'd14 || evq[0].cls != 3) begin
            errors++; $display("FAIL clr_event: code=%0d cls=%0d required 14/3", evq[0].code, evq[0].cls);
        end
        checks++;
        if (kp.key_code !== 4'd14 || kp.digit !== 4'd5) begin
            errors++; $display("FAIL clr_held: key_code=%0d digit=%0d required 14/5", kp.key_code, kp.digit);
        end
    endtask

    task automatic test_bounce();
        bit found;
        evq.delete();
        found = 0;
        for (int i = 0; i < 20 * SD && !found; i++) begin
            @(posedge clk);
            #1;
            if (kp.col_out === 4'b1101) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL bounce_wait: col1 never driven, col_out=%b", kp.col_out); end
        press(8);
        repeat (SD) @(posedge clk);
        #1 release_all();
        repeat (SD) @(posedge clk);
        #1;
        checks++;
        if (kp.col_out !== 4'b1011) begin errors++; $display("FAIL bounce_rot: got %b required 1011", kp.col_out); end
        wait_per(4);
        checks++;
        if (evq.size() != 0) begin errors++; $display("FAIL bounce_nopulse: got %0d events required 0", evq.size()); end
    endtask

    task automatic test_ghost();
        bit found;
        evq.delete();
        found = 0;
        for (int i = 0; i < 20 * SD && !found; i++) begin
            @(posedge clk); #1;
            if (kp.col_out === 4'b1011) found = 1;
        end
        pressed = 16'h0101;
        found = 0;
        for (int i = 0; i < 20 * SD && !found; i++) begin
            @(posedge clk); #1;
            if (kp.col_out === 4'b1110) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL ghost_wait: col0 never driven, col_out=%b", kp.col_out); end
        repeat (SD) @(posedge clk);
        #1;
        checks++;
        if (kp.col_out !== 4'b1101) begin errors++; $display("FAIL ghost_rot: got %b required 1101", kp.col_out); end
        release_all();
        wait_per(4);
        checks++;
        if (evq.size() != 0) begin errors++; $display("FAIL ghost_nopulse: got %0d events required 0", evq.size()); end
    endtask

    task automatic test_rollover();
        evq.delete();
        press(7); wait_per(12);
        press(9); wait_per(8);
        release_all(); wait_per(6);
        press(9); wait_per(12); release_all(); wait_per(6);
        checks++;
        if (evq.size() != 2) begin errors++; $display("FAIL roll_count: got %0d events required 2", evq.size()); end
        else begin
            checks++;
            if (evq[0].code !== 4'd7 || evq[0].dig !== 4'd7) begin
                errors++; $display("FAIL roll_first: code=%0d digit=%0d required 7/7", evq[0].code, evq[0].dig);
            end
            checks++;
            if (evq[1].code !== 4'd9 || evq[1].dig !== 4'd9) begin
                errors++; $display("FAIL roll_second: code=%0d digit=%0d required 9/9", evq[1].code, evq[1].dig);
            end
        end
    endtask

    task automatic test_reset_held();
        bit got;
        evq.delete();
        press(6);
        got = 0;
        for (int i = 0; i < 16 * SD && !got; i++) begin
            @(posedge clk); #1;
            if (evq.size() != 0) got = 1;
        end
        checks++;
        if (!got || evq[0].code !== 4'd6) begin errors++; $display("FAIL rh_accept: events=%0d, required key 6 accepted", evq.size()); end
        wait_per(2);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (kp.col_out !== 4'b1110 || kp.key_code !== 4'd0 || kp.digit !== 4'd0 || kp.op_code !== 2'd0 || kp.key_valid !== 1'b0) begin
            errors++; $display("FAIL rh_reset: col=%b key_code=%0d digit=%0d op=%0d kv=%b required 1110/0/0/0/0",
                kp.col_out, kp.key_code, kp.digit, kp.op_code, kp.key_valid);
        end
        release_all();
        wait_per(2);
        @(negedge clk) rst = 1'b0;
        wait_per(8);
        checks++;
        if (evq.size() != 1) begin errors++; $display("FAIL rh_nopulse: got %0d events required 1", evq.size()); end
    endtask

    task automatic test_random();
        int code, exp_cls;
        logic [3:0] exp_digit;
        logic [1:0] exp_op;
        exp_digit = 4'd0;
        exp_op    = 2'd0;
        for (int k = 0; k < 12; k++) begin
            evq.delete();
            code = int'($urandom_range(0, 15));
            exp_cls = cls_of(code);
            if (exp_cls == 0) exp_digit = 4'(code);
            if (exp_cls == 1) exp_op = 2'(code - 10);
            press(code);
            wait_per(int'($urandom_range(10, 16)));
            release_all();
            wait_per(int'($urandom_range(5, 8)));
            checks++;
            if (evq.size() != 1) begin
                errors++; $display("FAIL rnd%0d_count: key %0d gave %0d events required 1", k, code, evq.size());
            end else begin
                checks++;
                if (evq[0].code !== 4'(code) || evq[0].cls != exp_cls) begin
                    errors++; $display("FAIL rnd%0d_event: code=%0d cls=%0d required %0d/%0d", k, evq[0].code, evq[0].cls, code, exp_cls);
                end
                checks++;
                if (evq[0].dig !== exp_digit || evq[0].op !== exp_op) begin
                    errors++; $display("FAIL rnd%0d_held: digit=%0d op=%0d required %0d/%0d", k, evq[0].dig, evq[0].op, exp_digit, exp_op);
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_digit5();
        test_plus_eq();
        test_clear();
        test_bounce();
        test_ghost();
        test_rollover();
        test_reset_held();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
